// File: rtl/edge_stats_pkg.sv
// Shared types, default geometry and helpers for the edge focus statistics block.
// Contents:
//   state_e    - frame accumulator FSM states
//   DEF_*      - default 800x480 geometry, centred ROI and accumulator width
//   sat_add    - saturating add of an 8-bit edge value into an accumulator of width w
package edge_stats_pkg;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH  = 800;
    localparam int unsigned DEF_HEIGHT = 480;
    localparam int unsigned DEF_ROI_X0 = 200;
    localparam int unsigned DEF_ROI_X1 = 599;
    localparam int unsigned DEF_ROI_Y0 = 120;
    localparam int unsigned DEF_ROI_Y1 = 359;
    localparam int unsigned DEF_SUM_W  = 32;
    localparam int unsigned MAX_SUM_W  = 64;

    // acc is zero-extended to MAX_SUM_W; the result clamps at 2^w-1 instead of wrapping.
    function automatic logic [MAX_SUM_W-1:0] sat_add(input logic [MAX_SUM_W-1:0] acc,
                                                     input logic [7:0]           val,
                                                     input int unsigned          w);
        logic [MAX_SUM_W:0] sum;
        logic [MAX_SUM_W:0] lim;
        sum = {1'b0, acc} + {{(MAX_SUM_W - 7){1'b0}}, val};
        lim = ({{MAX_SUM_W{1'b0}}, 1'b1} << w) - {{MAX_SUM_W{1'b0}}, 1'b1};
        if (sum > lim) begin
            return lim[MAX_SUM_W-1:0];
        end
        return sum[MAX_SUM_W-1:0];
    endfunction

endpackage

// File: rtl/vga_position_tracker.sv
// Derives pixel column/line position from VGA blank and vsync.
// Ports:
//   VGA_CLK, reset_n - pixel clock, async active-low reset
//   iVGA_BLANK_N     - high during active pixels
//   iVGA_VS          - vertical sync, low between frames
//   x, y             - column / line of the current pixel (saturate at WIDTH / HEIGHT)
//   line_count_ok    - the lines seen so far equal HEIGHT
//   vs_fall          - combinational vsync falling edge for the current cycle
module vga_position_tracker
    import edge_stats_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned XW     = $clog2(WIDTH + 1),
    parameter int unsigned YW     = $clog2(HEIGHT + 1)
) (
    input  logic          VGA_CLK,
    input  logic          reset_n,
    input  logic          iVGA_BLANK_N,
    input  logic          iVGA_VS,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_count_ok,
    output logic          vs_fall
);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          vs_q;
    logic          blank_n_q;

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            x_q       <= '0;
            y_q       <= '0;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b1;
        end else begin
            vs_q      <= iVGA_VS;
            blank_n_q <= iVGA_BLANK_N;
            if (iVGA_BLANK_N) begin
                if (x_q < XW'(WIDTH)) begin
                    x_q <= x_q + 1'b1;
                end
            end else begin
                x_q <= '0;
            end
            // vsync low dominates a coincident end of line
            if (!iVGA_VS) begin
                y_q <= '0;
            end else if (blank_n_q && !iVGA_BLANK_N && (y_q < YW'(HEIGHT))) begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    assign x             = x_q;
    assign y             = y_q;
    assign line_count_ok = (y_q == YW'(HEIGHT));
    assign vs_fall       = vs_q & ~iVGA_VS;

endmodule

// File: rtl/edge_focus_stats.sv
// Per-frame sharpness metric: sums above-threshold edge magnitudes inside the ROI and
// publishes one saturated sum per frame, tracking the peak for auto-focus.
// Ports:
//   VGA_CLK, reset_n           - pixel clock, async active-low reset
//   iVGA_BLANK_N/HS/VS         - VGA timing from the filter stage (HS is not used)
//   edge_in, threshold         - edge magnitude and minimum counted value
//   clear_peak                 - synchronous peak clear
//   metric, metric_valid       - last published sum and its one-cycle strobe
//   frame_err                  - one-cycle strobe: frame had the wrong line count
//   peak_metric, is_peak       - largest metric since reset/clear, last publish set it
//   frame_count                - published frames, wraps
module edge_focus_stats
    import edge_stats_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned ROI_X0 = DEF_ROI_X0,
    parameter int unsigned ROI_X1 = DEF_ROI_X1,
    parameter int unsigned ROI_Y0 = DEF_ROI_Y0,
    parameter int unsigned ROI_Y1 = DEF_ROI_Y1,
    parameter int unsigned SUM_W  = DEF_SUM_W
) (
    input  logic             VGA_CLK,
    input  logic             reset_n,
    input  logic             iVGA_BLANK_N,
    input  logic             iVGA_HS,
    input  logic             iVGA_VS,
    input  logic [7:0]       edge_in,
    input  logic [7:0]       threshold,
    input  logic             clear_peak,
    output logic [SUM_W-1:0] metric,
    output logic             metric_valid,
    output logic             frame_err,
    output logic [SUM_W-1:0] peak_metric,
    output logic             is_peak,
    output logic [15:0]      frame_count
);

    localparam int unsigned XW = $clog2(WIDTH + 1);
    localparam int unsigned YW = $clog2(HEIGHT + 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_count_ok;
    logic          vs_fall;

    vga_position_tracker #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .XW    (XW),
        .YW    (YW)
    ) u_pos (
        .VGA_CLK      (VGA_CLK),
        .reset_n      (reset_n),
        .iVGA_BLANK_N (iVGA_BLANK_N),
        .iVGA_VS      (iVGA_VS),
        .x            (x),
        .y            (y),
        .line_count_ok(line_count_ok),
        .vs_fall      (vs_fall)
    );

    state_e           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] metric_q, metric_d;
    logic [SUM_W-1:0] peak_q, peak_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             is_peak_q, is_peak_d;
    logic [15:0]      fc_q, fc_d;

    logic                 hit;
    logic [MAX_SUM_W-1:0] acc_ext;
    logic [MAX_SUM_W-1:0] sum_wide;
    logic [SUM_W-1:0]     peak_base;
    logic                 unused_bits;

    assign hit = iVGA_BLANK_N
               && (x >= XW'(ROI_X0)) && (x <= XW'(ROI_X1))
               && (y >= YW'(ROI_Y0)) && (y <= YW'(ROI_Y1))
               && (edge_in >= threshold);

    always_comb begin
        acc_ext              = '0;
        acc_ext[SUM_W-1:0]   = acc_q;
        sum_wide             = sat_add(acc_ext, edge_in, SUM_W);
    end

    assign unused_bits = ^{iVGA_HS, sum_wide};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        metric_d  = metric_q;
        peak_d    = peak_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        is_peak_d = is_peak_q;
        fc_d      = fc_q;
        // a coincident clear is applied before the peak compare
        peak_base = clear_peak ? '0 : peak_q;
        if (clear_peak) begin
            peak_d    = '0;
            is_peak_d = 1'b0;
        end
        unique case (state_q)
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                end
            end
            ACCUM: begin
                if (hit) begin
                    acc_d = sum_wide[SUM_W-1:0];
                end
                if (vs_fall) begin
                    state_d = PUBLISH;
                    if (line_count_ok) begin
                        metric_d = acc_q;
                        valid_d  = 1'b1;
                        fc_d     = fc_q + 16'd1;
                        if (acc_q > peak_base) begin
                            peak_d    = acc_q;
                            is_peak_d = 1'b1;
                        end else begin
                            is_peak_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PUBLISH: begin
                state_d = ACCUM;
                acc_d   = '0;
            end
            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= WAIT_VS;
            acc_q     <= '0;
            metric_q  <= '0;
            peak_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            is_peak_q <= 1'b0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            metric_q  <= metric_d;
            peak_q    <= peak_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            is_peak_q <= is_peak_d;
            fc_q      <= fc_d;
        end
    end

    assign metric       = metric_q;
    assign metric_valid = valid_q;
    assign frame_err    = err_q;
    assign peak_metric  = peak_q;
    assign is_peak      = is_peak_q;
    assign frame_count  = fc_q;

endmodule

// File: tb/tb_edge_focus_stats.sv
// Directed bench: 8x4 frames, ROI x2..5 / y1..2, 32-bit and 8-bit accumulator instances.
module tb_edge_focus_stats;

    localparam int unsigned W = 8;
    localparam int unsigned H = 4;

    logic        VGA_CLK = 1'b0;
    logic        reset_n;
    logic        blank_n;
    logic        hs;
    logic        vs;
    logic [7:0]  edge_in;
    logic [7:0]  threshold;
    logic        clear_peak;

    logic [31:0] metric, peak_metric;
    logic        metric_valid, frame_err, is_peak;
    logic [15:0] frame_count;
    logic [7:0]  metric8, peak8;
    logic        valid8, err8, is_peak8;
    logic [15:0] fc8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int total_valid = 0;
    int total_err   = 0;
    int valid_cyc   = -1;
    int vs_cyc      = 0;
    int v0, e0;

    always #5 VGA_CLK = ~VGA_CLK;

    edge_focus_stats #(
        .WIDTH(W), .HEIGHT(H), .ROI_X0(2), .ROI_X1(5), .ROI_Y0(1), .ROI_Y1(2), .SUM_W(32)
    ) dut (
        .VGA_CLK(VGA_CLK), .reset_n(reset_n), .iVGA_BLANK_N(blank_n), .iVGA_HS(hs),
        .iVGA_VS(vs), .edge_in(edge_in), .threshold(threshold), .clear_peak(clear_peak),
        .metric(metric), .metric_valid(metric_valid), .frame_err(frame_err),
        .peak_metric(peak_metric), .is_peak(is_peak), .frame_count(frame_count)
    );

    edge_focus_stats #(
        .WIDTH(W), .HEIGHT(H), .ROI_X0(2), .ROI_X1(5), .ROI_Y0(1), .ROI_Y1(2), .SUM_W(8)
    ) dut8 (
        .VGA_CLK(VGA_CLK), .reset_n(reset_n), .iVGA_BLANK_N(blank_n), .iVGA_HS(hs),
        .iVGA_VS(vs), .edge_in(edge_in), .threshold(threshold), .clear_peak(clear_peak),
        .metric(metric8), .metric_valid(valid8), .frame_err(err8),
        .peak_metric(peak8), .is_peak(is_peak8), .frame_count(fc8)
    );

    always @(posedge VGA_CLK) cyc <= cyc + 1;

    always @(negedge VGA_CLK) begin
        if (metric_valid) begin
            total_valid <= total_valid + 1;
            valid_cyc   <= cyc;
        end
        if (frame_err) total_err <= total_err + 1;
    end

    task automatic tick();
        @(negedge VGA_CLK);
    endtask

    // lines x W active pixels, 2-cycle line blank, then a 3-cycle vsync low.
    // clr raises clear_peak on the vsync falling cycle only.
    task automatic send_frame(input int lines, input logic [7:0] e, input logic clr);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < int'(W); p++) begin
                blank_n = 1'b1; edge_in = e; tick();
            end
            blank_n = 1'b0; edge_in = 8'd0; hs = 1'b0; tick();
            hs = 1'b1; tick();
        end
        tick();
        vs = 1'b0; clear_peak = clr; vs_cyc = cyc; tick();
        clear_peak = 1'b0; tick(); tick();
        vs = 1'b1; tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick(); tick();
        checks++; if (metric !== 32'd0) begin failures++; $display("FAIL rst_metric got=%0d exp=0", metric); end
        checks++; if (metric_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", metric_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", frame_err); end
        checks++; if (peak_metric !== 32'd0) begin failures++; $display("FAIL rst_peak got=%0d exp=0", peak_metric); end
        checks++; if (is_peak !== 1'b0) begin failures++; $display("FAIL rst_is_peak got=%b exp=0", is_peak); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_fc got=%0d exp=0", frame_count); end
        checks++; if ({metric8, valid8, err8, peak8, is_peak8, fc8} !== 35'd0) begin
            failures++; $display("FAIL rst_dut8 got=%h exp=0", {metric8, valid8, err8, peak8, is_peak8, fc8});
        end
        reset_n = 1'b1; tick();
    endtask

    task automatic test_basic();
        threshold = 8'd5;
        v0 = total_valid; e0 = total_err;
        send_frame(H, 8'd10, 1'b0);
        checks++; if (total_valid - v0 !== 0) begin failures++; $display("FAIL t1_arm_valid got=%0d exp=0", total_valid - v0); end
        checks++; if (total_err - e0 !== 0) begin failures++; $display("FAIL t1_arm_err got=%0d exp=0", total_err - e0); end
        send_frame(H, 8'd10, 1'b0);
        checks++; if (total_valid - v0 !== 1) begin failures++; $display("FAIL t1_valid_cycles got=%0d exp=1", total_valid - v0); end
        checks++; if (valid_cyc !== vs_cyc + 1) begin failures++; $display("FAIL t1_latency got=%0d exp=%0d", valid_cyc, vs_cyc + 1); end
        checks++; if (metric !== 32'd80) begin failures++; $display("FAIL t1_metric got=%0d exp=80", metric); end
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL t1_fc got=%0d exp=1", frame_count); end
        checks++; if (peak_metric !== 32'd80) begin failures++; $display("FAIL t1_peak got=%0d exp=80", peak_metric); end
        checks++; if (is_peak !== 1'b1) begin failures++; $display("FAIL t1_is_peak got=%b exp=1", is_peak); end
    endtask

    task automatic test_threshold();
        threshold = 8'd11;
        v0 = total_valid;
        send_frame(H, 8'd10, 1'b0);
        checks++; if (total_valid - v0 !== 1) begin failures++; $display("FAIL t2_valid got=%0d exp=1", total_valid - v0); end
        checks++; if (metric !== 32'd0) begin failures++; $display("FAIL t2_metric got=%0d exp=0", metric); end
        checks++; if (is_peak !== 1'b0) begin failures++; $display("FAIL t2_is_peak got=%b exp=0", is_peak); end
        checks++; if (peak_metric !== 32'd80) begin failures++; $display("FAIL t2_peak got=%0d exp=80", peak_metric); end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL t2_fc got=%0d exp=2", frame_count); end
    endtask

    task automatic test_saturation();
        threshold = 8'd0;
        send_frame(H, 8'd255, 1'b0);
        checks++; if (metric !== 32'd2040) begin failures++; $display("FAIL t3_metric32 got=%0d exp=2040", metric); end
        checks++; if (metric8 !== 8'd255) begin failures++; $display("FAIL t3_metric8 got=%0d exp=255", metric8); end
        checks++; if (fc8 !== 16'd3) begin failures++; $display("FAIL t3_fc8 got=%0d exp=3", fc8); end
        checks++; if (peak_metric !== 32'd2040) begin failures++; $display("FAIL t3_peak got=%0d exp=2040", peak_metric); end
    endtask

    task automatic test_short_frame();
        threshold = 8'd5;
        v0 = total_valid; e0 = total_err;
        send_frame(H - 1, 8'd10, 1'b0);
        checks++; if (total_err - e0 !== 1) begin failures++; $display("FAIL t4_err_cycles got=%0d exp=1", total_err - e0); end
        checks++; if (total_valid - v0 !== 0) begin failures++; $display("FAIL t4_valid got=%0d exp=0", total_valid - v0); end
        checks++; if (metric !== 32'd2040) begin failures++; $display("FAIL t4_metric got=%0d exp=2040", metric); end
        checks++; if (frame_count !== 16'd3) begin failures++; $display("FAIL t4_fc got=%0d exp=3", frame_count); end
        checks++; if (peak_metric !== 32'd2040) begin failures++; $display("FAIL t4_peak got=%0d exp=2040", peak_metric); end
    endtask

    task automatic test_peak_clear();
        clear_peak = 1'b1; tick(); clear_peak = 1'b0;
        checks++; if (peak_metric !== 32'd0) begin failures++; $display("FAIL t5_clr_peak got=%0d exp=0", peak_metric); end
        checks++; if (is_peak !== 1'b0) begin failures++; $display("FAIL t5_clr_is_peak got=%b exp=0", is_peak); end
        threshold = 8'd5;
        send_frame(H, 8'd10, 1'b0);
        checks++; if (peak_metric !== 32'd80 || is_peak !== 1'b1) begin
            failures++; $display("FAIL t5_a got=%0d/%b exp=80/1", peak_metric, is_peak);
        end
        send_frame(H, 8'd5, 1'b0);
        checks++; if (metric !== 32'd40) begin failures++; $display("FAIL t5_b_metric got=%0d exp=40", metric); end
        checks++; if (peak_metric !== 32'd80 || is_peak !== 1'b0) begin
            failures++; $display("FAIL t5_b got=%0d/%b exp=80/0", peak_metric, is_peak);
        end
        send_frame(H, 8'd5, 1'b1);
        checks++; if (peak_metric !== 32'd40 || is_peak !== 1'b1) begin
            failures++; $display("FAIL t5_c got=%0d/%b exp=40/1", peak_metric, is_peak);
        end
        checks++; if (frame_count !== 16'd6) begin failures++; $display("FAIL t5_fc got=%0d exp=6", frame_count); end
    endtask

    task automatic test_reset_mid();
        threshold = 8'd5;
        for (int p = 0; p < int'(W); p++) begin blank_n = 1'b1; edge_in = 8'd10; tick(); end
        blank_n = 1'b0; edge_in = 8'd0; tick(); tick();
        for (int p = 0; p < 4; p++) begin blank_n = 1'b1; edge_in = 8'd10; tick(); end
        reset_n = 1'b0; #1;
        checks++; if ({metric, metric_valid, frame_err, peak_metric, is_peak, frame_count} !== 83'd0) begin
            failures++; $display("FAIL t6_async_clear got=%0d/%0d/%0d exp=0/0/0", metric, peak_metric, frame_count);
        end
        tick(); tick(); tick();
        blank_n = 1'b0; edge_in = 8'd0;
        reset_n = 1'b1; tick();
        v0 = total_valid; e0 = total_err;
        send_frame(H, 8'd10, 1'b0);
        checks++; if (total_valid - v0 !== 0 || total_err - e0 !== 0) begin
            failures++; $display("FAIL t6_arm_strobe got=%0d/%0d exp=0/0", total_valid - v0, total_err - e0);
        end
        send_frame(H, 8'd10, 1'b0);
        checks++; if (total_valid - v0 !== 1) begin failures++; $display("FAIL t6_valid got=%0d exp=1", total_valid - v0); end
        checks++; if (valid_cyc !== vs_cyc + 1) begin failures++; $display("FAIL t6_latency got=%0d exp=%0d", valid_cyc, vs_cyc + 1); end
        checks++; if (metric !== 32'd80) begin failures++; $display("FAIL t6_metric got=%0d exp=80", metric); end
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL t6_fc got=%0d exp=1", frame_count); end
        checks++; if (peak_metric !== 32'd80 || is_peak !== 1'b1) begin
            failures++; $display("FAIL t6_peak got=%0d/%b exp=80/1", peak_metric, is_peak);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        blank_n    = 1'b0;
        hs         = 1'b1;
        vs         = 1'b1;
        edge_in    = 8'd0;
        threshold  = 8'd5;
        clear_peak = 1'b0;
        test_reset();
        test_basic();
        test_threshold();
        test_saturation();
        test_short_frame();
        test_peak_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
